sync_fifo_ctrl: RTL

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_ptr.sv | 16 +
 rtl/sync_fifo_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing for the synchronous FIFO controller: data width, pointer
// width, number of storage entries and the occupancy counter width.
package fifo_pkg;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = AW + 1;
endpackage

// File: rtl/fifo_ptr.sv
// AW-bit wrapping address counter with synchronous clear and count enable.
module fifo_ptr #(
  parameter int AW = fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (clr)     ptr <= '0;
    else if (en) ptr <= ptr + AW'(1);
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FIFO controller driving an external 1-cycle-latency storage array.
// Push has priority over pop, so storage never sees read and write together.
module sync_fifo_ctrl #(
  parameter int DW    = fifo_pkg::DW,
  parameter int AW    = fifo_pkg::AW,
  parameter int DEPTH = fifo_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          push_ready,
  output logic          pop_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_wr_add,
  output logic [AW-1:0] ram_rd_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = AW + 1;

  logic          push_acc;
  logic          pop_acc;
  logic          rd_vld_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop that collides with an accepted push is refused and must be held.
  assign push_acc = push && !full && !rst;
  assign pop_acc  = pop && !empty && !(push && !full) && !rst;

  assign push_ready = !full;
  assign pop_ready  = !empty && !(push && !full);

  assign overflow  = push && full && !rst;
  assign underflow = pop && empty && !rst;

  assign ram_we     = push_acc;
  assign ram_re     = pop_acc;
  assign ram_wr_add = wr_ptr;
  assign ram_rd_add = rd_ptr;
  assign ram_din    = din;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk (clk),
    .clr (rst),
    .en  (push_acc),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk (clk),
    .clr (rst),
    .en  (pop_acc),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (push_acc) count <= count + CW'(1);
    else if (pop_acc)  count <= count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rd_vld_q <= 1'b0;
    else     rd_vld_q <= pop_acc;
  end

  // Masking with rst drops a read that was in flight when reset arrived.
  assign dout_valid = rd_vld_q && !rst;
  assign dout       = ram_dout;

endmodule
